store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
Post-commit store queue inside the memory stage of the multi-cycle cached core.
- Accepts retired stores from the memory stage and holds them in a small FIFO.
- Forwards buffered bytes to younger loads, byte by byte.
- Drains entries in order to the data-cache write port over a valid/ready handshake, so stores do not stall the pipeline.

Parameters:
DEPTH, 4, number of entries; must be a power of two and at least 2
ADDR_W, 32, byte-address width
DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
enq_valid  in  1  memory stage presents a store
enq_ready  out  1  buffer can accept the store
enq_addr  in  ADDR_W  store byte address; word index is addr[ADDR_W-1:2]
enq_data  in  DATA_W  store data, already lane-aligned
enq_be  in  DATA_W/8  byte enables
lookup_addr  in  ADDR_W  load address from the memory stage
fwd_mask  out  DATA_W/8  bytes supplied by the buffer
fwd_data  out  DATA_W  forwarded bytes; lanes not set in fwd_mask are 0
mem_valid  out  1  head entry offered to the cache write port
mem_ready  in  1  cache accepts the head entry
mem_addr  out  ADDR_W  head word address, bits [1:0] forced to 0
mem_data  out  DATA_W  head data
mem_be  out  DATA_W/8  head byte enables
empty  out  1  no valid entries
full  out  1  count equals DEPTH

Behaviour:
Storage and reset
- Circular FIFO with head pointer, tail pointer and a count of width log2(DEPTH)+1.
- Pointers wrap modulo DEPTH.
- Reset asserted (low): all valid bits, pointers and count clear immediately.
- Outputs under reset: mem_valid=0, empty=1, full=0, enq_ready=1, fwd_mask=0.
- Reset asserted mid-drain discards every entry. No partial write is guaranteed.

Enqueue
- enq_ready = !full, combinational. There is no same-cycle bypass when full.
- Handshake fires when enq_valid && enq_ready.
- Coalescing: if the youngest valid entry has the same word address and is not the head, the store merges into it. Bytes with be set overwrite; that entry's be becomes old be | new be. Count is unchanged.
- Otherwise the store is written at the tail; tail and count increment.
- An enqueued store is visible to lookup from the next cycle on. The same-cycle enqueue is not forwarded.

Drain
- mem_valid = !empty.
- mem_addr, mem_data and mem_be come from the head entry and stay stable while mem_valid && !mem_ready.
- Entry pops on the edge where mem_valid && mem_ready; head increments and count decrements.
- Simultaneous enqueue and pop: both take effect and count is unchanged.
- Full with simultaneous pop: enq_ready is still 0 that cycle.

Forwarding (combinational)
- Match every valid entry whose word address equals lookup_addr[ADDR_W-1:2].
- Each byte lane is resolved independently. The youngest matching entry with that be bit set supplies the byte.
- fwd_mask is the OR of the matching be bits.
- The memory stage merges fwd_data with cache data for lanes not set in fwd_mask.
- The head entry being popped this cycle still forwards. After the edge, the cache holds the data.

Invariants
- Stores reach the cache in program order.
- An entry is never dropped except on reset.

Decomposition:
- Shared package sb_pkg holds:
  - the entry typedef (valid, word addr, data, be);
  - the DEPTH default;
  - the log2 pointer-width constant;
  - the byte-lane count.
- One sub-module, sb_fwd_lane: a per-byte-lane priority selector, instantiated DATA_W/8 times. Given per-entry match and be bits in age order, it produces one mask bit and one data byte.
- All state stays in store_buffer.

Test Plan:
1. Enqueue SB addr 0x104, data 0x00000080, be=0001, with mem_ready held 0; next cycle lookup 0x104 -> fwd_mask=0001, fwd_data=0x00000080. Then raise mem_ready -> one mem_valid handshake with mem_addr=0x104, mem_be=0001; empty=1 afterwards.
2. Enqueue 0x200 be=0011 data 0x0000BEEF, then 0x200 be=0100 data 0x00AA0000, with mem_ready=0 -> first store is the head, so no coalescing. Lookup 0x200 -> fwd_mask=0111, fwd_data=0x00AABEEF. Two drains occur in order.
3. Enqueue 0x300 (head), 0x304, then 0x304 again with be=1000 -> merges into the 0x304 entry; count=2.
4. With mem_ready=0, enqueue DEPTH distinct words -> full=1, enq_ready=0; a further enq_valid is not accepted. Then one pop with a simultaneous enqueue attempt -> count=DEPTH-1, and the enqueue is accepted only next cycle.
5. Toggle mem_ready randomly over 8 stores to distinct words -> the drain sequence of addresses and data exactly matches enqueue order; mem_* are stable while stalled.
6. Pull reset low with 3 entries pending and mem_valid=1 -> mem_valid=0, empty=1 asynchronously. After release, lookup of any previously stored address returns fwd_mask=0.

Source files
------------

// File: rtl/sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sb_pkg
// Description : Shared types and constants for the post-commit store buffer.
//               Holds the default geometry, the pointer width, the byte-lane
//               count and the entry layout (valid, word address, data, be).
// Revision    : 1.0 - initial release
// ============================================================================
package sb_pkg;

  localparam int c_DEPTH  = 4;                 // default number of entries
  localparam int c_ADDR_W = 32;                // default byte-address width
  localparam int c_DATA_W = 32;                // default data width
  localparam int c_PTR_W  = $clog2(c_DEPTH);   // head/tail pointer width
  localparam int c_LANES  = c_DATA_W / 8;      // byte lanes per word

  // One buffered store at the default geometry. The word address drops the
  // two byte-offset bits because stores are tracked per 32-bit word.
  typedef struct packed {
    logic                  valid;
    logic [c_ADDR_W-3:0]   waddr;
    logic [c_DATA_W-1:0]   data;
    logic [c_LANES-1:0]    be;
  } sb_entry_t;

endpackage : sb_pkg
`default_nettype wire

// File: rtl/sb_fwd_lane.sv
`default_nettype none
// ============================================================================
// Module      : sb_fwd_lane
// Description : Per-byte-lane forwarding selector. Inputs are presented in
//               age order (index 0 = oldest entry). The youngest entry that
//               matches the load word and has this lane's byte enable set
//               supplies the byte.
// Ports       : i_match  - per-entry word-address match (valid folded in)
//               i_be     - per-entry byte enable for this lane
//               i_data   - per-entry byte for this lane, 8 bits per entry
//               o_mask   - lane supplied by the buffer
//               o_byte   - forwarded byte, 0 when o_mask is clear
// Revision    : 1.0 - initial release
// ============================================================================
module sb_fwd_lane
  import sb_pkg::*;
#(
  parameter int DEPTH = c_DEPTH
) (
  input  logic [DEPTH-1:0]   i_match,
  input  logic [DEPTH-1:0]   i_be,
  input  logic [DEPTH*8-1:0] i_data,
  output logic               o_mask,
  output logic [7:0]         o_byte
);

  // Scan oldest to youngest so the last hit (the youngest) wins.
  always_comb begin
    o_mask = 1'b0;
    o_byte = 8'h00;
    for (int k = 0; k < DEPTH; k++) begin
      if (i_match[k] && i_be[k]) begin
        o_mask = 1'b1;
        o_byte = i_data[k*8 +: 8];
      end
    end
  end

endmodule : sb_fwd_lane
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Post-commit store queue. Retired stores are held in a small
//               circular FIFO, coalesced into the youngest entry when they
//               hit the same word (unless that entry is the head), forwarded
//               byte-by-byte to younger loads, and drained in order to the
//               data-cache write port over a valid/ready handshake.
// Ports       : clk, reset (async, active-low)
//               enq_valid/enq_ready/enq_addr/enq_data/enq_be - store input
//               lookup_addr, fwd_mask, fwd_data              - load forwarding
//               mem_valid/mem_ready/mem_addr/mem_data/mem_be - cache drain
//               empty, full                                  - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH  = c_DEPTH,
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enq_valid,
  output logic                enq_ready,
  input  logic [ADDR_W-1:0]   enq_addr,
  input  logic [DATA_W-1:0]   enq_data,
  input  logic [DATA_W/8-1:0] enq_be,
  input  logic [ADDR_W-1:0]   lookup_addr,
  output logic [DATA_W/8-1:0] fwd_mask,
  output logic [DATA_W-1:0]   fwd_data,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_data,
  output logic [DATA_W/8-1:0] mem_be,
  output logic                empty,
  output logic                full
);

  localparam int c_PB = $clog2(DEPTH);
  localparam int c_NB = DATA_W / 8;
  localparam int c_WA = ADDR_W - 2;

  // Storage
  logic [DEPTH-1:0]  r_valid;
  logic [c_WA-1:0]   r_waddr [DEPTH];
  logic [DATA_W-1:0] r_data  [DEPTH];
  logic [c_NB-1:0]   r_be    [DEPTH];
  logic [c_PB-1:0]   r_head;
  logic [c_PB-1:0]   r_tail;
  logic [c_PB:0]     r_count;

  logic            w_full;
  logic            w_empty;
  logic            w_enq_fire;
  logic            w_pop;
  logic            w_coalesce;
  logic            w_push;
  logic [c_PB-1:0] w_young;
  logic [c_WA-1:0] w_enq_word;
  logic [c_WA-1:0] w_lk_word;
  logic            w_unused;

  assign w_full     = (r_count == (c_PB+1)'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_young    = r_tail - c_PB'(1);
  assign w_enq_word = enq_addr[ADDR_W-1:2];
  assign w_lk_word  = lookup_addr[ADDR_W-1:2];
  assign w_unused   = ^{enq_addr[1:0], lookup_addr[1:0]};

  assign w_enq_fire = enq_valid && !w_full;
  assign w_pop      = !w_empty && mem_ready;

  // The youngest entry is the head exactly when one entry is present, so
  // merging requires at least two entries; this keeps a merge from racing
  // with the head being handed to the cache.
  assign w_coalesce = w_enq_fire && (r_count >= (c_PB+1)'(2)) &&
                      r_valid[w_young] && (r_waddr[w_young] == w_enq_word);
  assign w_push     = w_enq_fire && !w_coalesce;

  // Control state: cleared immediately by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + c_PB'(1);
      end
      // Push never targets the head slot: that would need count 0 (no pop)
      // or count DEPTH (no push).
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + c_PB'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_PB+1)'(1);
        2'b01:   r_count <= r_count - (c_PB+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload: only meaningful where the valid bit is set, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_waddr[r_tail] <= w_enq_word;
      r_data[r_tail]  <= enq_data;
      r_be[r_tail]    <= enq_be;
    end else if (w_coalesce) begin
      r_be[w_young] <= r_be[w_young] | enq_be;
      for (int b = 0; b < c_NB; b++) begin
        if (enq_be[b]) begin
          r_data[w_young][b*8 +: 8] <= enq_data[b*8 +: 8];
        end
      end
    end
  end

  // Re-order entries by age (index 0 = head) and slice them per byte lane.
  logic [DEPTH-1:0]   w_match;
  logic [DEPTH-1:0]   w_lane_be   [c_NB];
  logic [DEPTH*8-1:0] w_lane_data [c_NB];

  always_comb begin
    w_match = '0;
    for (int b = 0; b < c_NB; b++) begin
      w_lane_be[b]   = '0;
      w_lane_data[b] = '0;
    end
    for (int k = 0; k < DEPTH; k++) begin
      w_match[k] = r_valid[r_head + c_PB'(k)] &&
                   (r_waddr[r_head + c_PB'(k)] == w_lk_word);
      for (int b = 0; b < c_NB; b++) begin
        w_lane_be[b][k]          = r_be[r_head + c_PB'(k)][b];
        w_lane_data[b][k*8 +: 8] = r_data[r_head + c_PB'(k)][b*8 +: 8];
      end
    end
  end

  for (genvar b = 0; b < c_NB; b++) begin : g_lane
    sb_fwd_lane #(
      .DEPTH (DEPTH)
    ) u_lane (
      .i_match (w_match),
      .i_be    (w_lane_be[b]),
      .i_data  (w_lane_data[b]),
      .o_mask  (fwd_mask[b]),
      .o_byte  (fwd_data[b*8 +: 8])
    );
  end

  assign enq_ready = !w_full;
  assign empty     = w_empty;
  assign full      = w_full;
  assign mem_valid = !w_empty;
  assign mem_addr  = {r_waddr[r_head], 2'b00};
  assign mem_data  = r_data[r_head];
  assign mem_be    = r_be[r_head];

endmodule : store_buffer
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Self-checking bench for store_buffer. A queue-based model of
//               the buffer (program-ordered list of stores, merge into the
//               youngest non-head entry, youngest-wins byte forwarding)
//               predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_addr;
  logic [31:0] enq_data;
  logic [3:0]  enq_be;
  logic [31:0] lookup_addr;
  logic [3:0]  fwd_mask;
  logic [31:0] fwd_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic        empty;
  logic        full;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .enq_addr    (enq_addr),
    .enq_data    (enq_data),
    .enq_be      (enq_be),
    .lookup_addr (lookup_addr),
    .fwd_mask    (fwd_mask),
    .fwd_data    (fwd_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_be      (mem_be),
    .empty       (empty),
    .full        (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        last_fire;
  logic        prev_stall = 1'b0;
  logic [31:0] sv_addr, sv_data;
  logic [3:0]  sv_be;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Youngest store with the byte enabled supplies each lane.
  function automatic void model_fwd(input logic [31:0] la, output logic [3:0] m,
                                    output logic [31:0] d);
    m = '0;
    d = '0;
    foreach (q[i]) begin
      if (q[i].waddr == la[31:2]) begin
        for (int b = 0; b < 4; b++) begin
          if (q[i].be[b]) begin
            m[b]         = 1'b1;
            d[b*8 +: 8]  = q[i].data[b*8 +: 8];
          end
        end
      end
    end
  endfunction

  task automatic peek(input logic [31:0] la);
    enq_valid   = 1'b0;
    lookup_addr = la;
    #1;
  endtask

  // One clock cycle: drive, check every output against the model, advance.
  task automatic cyc(input logic ev, input logic [31:0] ea, input logic [31:0] ed,
                     input logic [3:0] eb, input logic mr, input logic [31:0] la);
    logic [3:0]  m;
    logic [31:0] d;
    logic        fire, pop, merge;
    ent_t        e;
    int          sz;
    enq_valid = ev; enq_addr = ea; enq_data = ed; enq_be = eb;
    mem_ready = mr; lookup_addr = la;
    #1;
    sz = q.size();
    chk("empty", empty, (sz == 0));
    chk("full", full, (sz == DEPTH));
    chk("enq_ready", enq_ready, (sz != DEPTH));
    chk("mem_valid", mem_valid, (sz != 0));
    if (sz != 0) begin
      chk("mem_addr", mem_addr, {q[0].waddr, 2'b00});
      chk("mem_data", mem_data, q[0].data);
      chk("mem_be", mem_be, q[0].be);
    end
    if (prev_stall) begin
      chk("stable_addr", mem_addr, sv_addr);
      chk("stable_data", mem_data, sv_data);
      chk("stable_be", mem_be, sv_be);
    end
    model_fwd(la, m, d);
    chk("fwd_mask", fwd_mask, m);
    chk("fwd_data", fwd_data, d);
    fire  = ev && (sz < DEPTH);
    pop   = (sz > 0) && mr;
    merge = fire && (sz >= 2) && (q[sz-1].waddr == ea[31:2]);
    prev_stall = (sz > 0) && !mr;
    sv_addr = mem_addr; sv_data = mem_data; sv_be = mem_be;
    last_fire = fire;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (merge) begin
      e = q[q.size()-1];
      e.be = e.be | eb;
      for (int b = 0; b < 4; b++) if (eb[b]) e.data[b*8 +: 8] = ed[b*8 +: 8];
      q[q.size()-1] = e;
    end else if (fire) begin
      e.waddr = ea[31:2]; e.data = ed; e.be = eb;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain_all(input string tag);
    int g = 0;
    while (q.size() != 0 && g < 50) begin
      cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
      g++;
    end
    #1;
    chk(tag, empty, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int acc;
    int g;
    logic [31:0] la;
    reset = 1'b0; enq_valid = 1'b0; enq_addr = '0; enq_data = '0; enq_be = '0;
    mem_ready = 1'b0; lookup_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_enq_ready", enq_ready, 1'b1);
    chk("rst_fwd_mask", fwd_mask, 4'h0);
    @(negedge clk);
    reset = 1'b1;

    // 1: single byte store, forward, drain
    cyc(1'b1, 32'h104, 32'h0000_0080, 4'b0001, 1'b0, 32'h0);
    peek(32'h104);
    chk("t1_fwd_mask", fwd_mask, 4'b0001);
    chk("t1_fwd_data", fwd_data, 32'h0000_0080);
    chk("t1_mem_addr", mem_addr, 32'h104);
    chk("t1_mem_be", mem_be, 4'b0001);
    cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h104);
    peek(32'h104);
    chk("t1_empty", empty, 1'b1);
    chk("t1_fwd_gone", fwd_mask, 4'h0);

    // 2: second store to the head word is not merged
    cyc(1'b1, 32'h200, 32'h0000_BEEF, 4'b0011, 1'b0, 32'h0);
    cyc(1'b1, 32'h200, 32'h00AA_0000, 4'b0100, 1'b0, 32'h200);
    peek(32'h200);
    chk("t2_fwd_mask", fwd_mask, 4'b0111);
    chk("t2_fwd_data", fwd_data, 32'h00AA_BEEF);
    chk("t2_head_be", mem_be, 4'b0011);
    cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h200);
    peek(32'h200);
    chk("t2_second_be", mem_be, 4'b0100);
    drain_all("t2_empty");

    // 3: merge into the youngest non-head entry
    cyc(1'b1, 32'h300, 32'h1111_1111, 4'b1111, 1'b0, 32'h0);
    cyc(1'b1, 32'h304, 32'h2222_2222, 4'b1111, 1'b0, 32'h0);
    cyc(1'b1, 32'h304, 32'hAA00_0000, 4'b1000, 1'b0, 32'h304);
    peek(32'h304);
    chk("t3_fwd_data", fwd_data, 32'hAA22_2222);
    cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h304);
    cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h304);
    peek(32'h304);
    chk("t3_two_entries", empty, 1'b1);

    // 4: fill, refuse, pop with simultaneous enqueue attempt
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, 32'h400 + 32'(4*i), 32'hC0DE_0000 + 32'(i), 4'b1111, 1'b0, 32'h400);
    peek(32'h500);
    chk("t4_full", full, 1'b1);
    chk("t4_enq_ready", enq_ready, 1'b0);
    cyc(1'b1, 32'h500, 32'h5555_5555, 4'b1111, 1'b0, 32'h500);
    cyc(1'b1, 32'h504, 32'h6666_6666, 4'b1111, 1'b1, 32'h504);
    peek(32'h504);
    chk("t4_not_full", full, 1'b0);
    chk("t4_ready_next", enq_ready, 1'b1);
    chk("t4_rejected", fwd_mask, 4'h0);
    cyc(1'b1, 32'h504, 32'h6666_6666, 4'b1111, 1'b0, 32'h504);
    peek(32'h504);
    chk("t4_refull", full, 1'b1);
    drain_all("t4_empty");

    // 5: random drain back-pressure, distinct words, order preserved
    acc = 0; g = 0;
    while ((acc < 8 || q.size() != 0) && g < 300) begin
      la = 32'h1000 + 32'(4 * $urandom_range(0, 8));
      cyc((acc < 8) && ($urandom_range(0, 1) == 1), 32'h1000 + 32'(4*acc),
          $urandom, 4'($urandom_range(1, 15)), ($urandom_range(0, 2) == 0), la);
      if (last_fire) acc++;
      g++;
    end
    #1;
    chk("t5_empty", empty, 1'b1);

    // random coalescing over two words
    for (int i = 0; i < 60; i++)
      cyc(($urandom_range(0, 1) == 1), 32'h2000 + 32'(4 * $urandom_range(0, 1)),
          $urandom, 4'($urandom_range(1, 15)), ($urandom_range(0, 3) == 0),
          32'h2000 + 32'(4 * $urandom_range(0, 1)));
    drain_all("t5_coal_empty");

    // 6: asynchronous reset with entries pending
    cyc(1'b1, 32'h600, 32'hAAAA_0001, 4'b1111, 1'b0, 32'h0);
    cyc(1'b1, 32'h604, 32'hAAAA_0002, 4'b1111, 1'b0, 32'h0);
    cyc(1'b1, 32'h608, 32'hAAAA_0003, 4'b1111, 1'b0, 32'h0);
    peek(32'h600);
    chk("t6_pending", mem_valid, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_mem_valid", mem_valid, 1'b0);
    chk("t6_empty", empty, 1'b1);
    chk("t6_full", full, 1'b0);
    chk("t6_enq_ready", enq_ready, 1'b1);
    chk("t6_fwd_mask", fwd_mask, 4'h0);
    q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    peek(32'h604);
    chk("t6_after_604", fwd_mask, 4'h0);
    peek(32'h608);
    chk("t6_after_608", fwd_mask, 4'h0);
    cyc(1'b1, 32'h700, 32'h1234_5678, 4'b1111, 1'b0, 32'h700);
    peek(32'h700);
    chk("t6_reuse", fwd_data, 32'h1234_5678);
    drain_all("t6_final_empty");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_store_buffer
`default_nettype wire
